// File: rtl/mmio_perf_tohost_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_perf_tohost_pkg
// Brief    : Register offsets, pass code and run-state encoding shared by the
//            MMIO perf/tohost block and its counter sub-module.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_perf_tohost_pkg;

    localparam logic [2:0] REG_TOHOST      = 3'd0;
    localparam logic [2:0] REG_CTRL        = 3'd1;
    localparam logic [2:0] REG_MCYCLE_LO   = 3'd2;
    localparam logic [2:0] REG_MCYCLE_HI   = 3'd3;
    localparam logic [2:0] REG_MINSTRET_LO = 3'd4;
    localparam logic [2:0] REG_MINSTRET_HI = 3'd5;
    localparam logic [2:0] REG_BR_PRED     = 3'd6;
    localparam logic [2:0] REG_BR_MISP     = 3'd7;

    localparam logic [31:0] PASS_CODE_DEFAULT  = 32'h0000_0777;
    localparam int          REGION_BIT_DEFAULT = 28;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } run_state_e;

endpackage
`default_nettype wire

// File: rtl/mmio_perf_tohost_perf_cnt64.sv
`default_nettype none
// ============================================================================
// Module   : perf_cnt64
// Brief    : 64-bit event counter with clear, increment and a shadow of the
//            upper word captured whenever the lower word is read.
// Revision : 1.0 - initial release
// ============================================================================
module perf_cnt64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        clr_i,
    input  logic        snap_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_shadow_o
);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        // Clear has priority so a clear coinciding with an event leaves zero.
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
        if (snap_i) begin
            shadow_d = cnt_q[63:32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign lo_o        = cnt_q[31:0];
    assign hi_shadow_o = shadow_q;

endmodule
`default_nettype wire

// File: rtl/mmio_perf_tohost.sv
`default_nettype none
// ============================================================================
// Module   : mmio_perf_tohost
// Brief    : dbus MMIO slave capturing the end-of-test tohost store and
//            exposing cycle/instret/branch counters. Branch counters exist only
//            when PERF_BRANCH_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_perf_tohost
    import mmio_perf_tohost_pkg::*;
#(
    parameter logic [31:0] PASS_CODE  = PASS_CODE_DEFAULT,
    parameter int          REGION_BIT = REGION_BIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    input  logic [3:0]  dbus_wstrb_i,
    input  logic        dbus_rvalid_i,
    output logic [31:0] dbus_rdata_o,
    output logic        dbus_rdata_v_o,
    input  logic        retire_i,
    input  logic        ctrl_tsfr_i,
    input  logic        br_misp_i,
    output logic        fini_o,
    output logic        pass_o,
    output logic [31:0] tohost_o
);

    logic        w_sel, w_wr, w_rd, w_clr, w_tohost_wr, w_cnt_en;
    logic [2:0]  w_idx;
    logic [31:0] w_cyc_lo, w_cyc_sh, w_ins_lo, w_ins_sh, w_bp, w_bm;
    logic [31:0] w_rmux;
    logic        w_unused_addr;

    run_state_e  state_q, state_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic        pass_q, pass_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_v_q, rdata_v_d;

    assign w_sel         = dbus_addr_i[REGION_BIT];
    assign w_idx         = dbus_addr_i[4:2];
    assign w_wr          = w_sel && dbus_wvalid_i && (dbus_wstrb_i == 4'hf);
    assign w_rd          = w_sel && dbus_rvalid_i;
    assign w_clr         = w_wr && (w_idx == REG_CTRL) && dbus_wdata_i[1];
    assign w_tohost_wr   = w_wr && (w_idx == REG_TOHOST) && (state_q != ST_DONE);
    assign w_cnt_en      = ctrl_en_q && !fini_o;
    assign w_unused_addr = ^{dbus_addr_i[31:5], dbus_addr_i[1:0]};

    perf_cnt64 u_mcycle (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_cnt_en),
        .clr_i       (w_clr),
        .snap_i      (w_rd && (w_idx == REG_MCYCLE_LO)),
        .lo_o        (w_cyc_lo),
        .hi_shadow_o (w_cyc_sh)
    );

    perf_cnt64 u_minstret (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_cnt_en && retire_i),
        .clr_i       (w_clr),
        .snap_i      (w_rd && (w_idx == REG_MINSTRET_LO)),
        .lo_o        (w_ins_lo),
        .hi_shadow_o (w_ins_sh)
    );

`ifdef PERF_BRANCH_CNT_EN
    logic [31:0] br_pred_q, br_pred_d, br_misp_q, br_misp_d;

    always_comb begin
        br_pred_d = br_pred_q;
        br_misp_d = br_misp_q;
        if (w_clr) begin
            br_pred_d = '0;
            br_misp_d = '0;
        end else if (w_cnt_en && ctrl_tsfr_i) begin
            br_pred_d = br_pred_q + 32'd1;
            if (br_misp_i) begin
                br_misp_d = br_misp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_pred_q <= '0;
            br_misp_q <= '0;
        end else begin
            br_pred_q <= br_pred_d;
            br_misp_q <= br_misp_d;
        end
    end

    assign w_bp = br_pred_q;
    assign w_bm = br_misp_q;
`else
    logic w_unused_br;
    assign w_unused_br = ctrl_tsfr_i ^ br_misp_i;
    assign w_bp        = '0;
    assign w_bm        = '0;
`endif

    always_comb begin
        w_rmux = '0;
        case (w_idx)
            REG_TOHOST:      w_rmux = tohost_q;
            REG_CTRL:        w_rmux = {31'd0, ctrl_en_q};
            REG_MCYCLE_LO:   w_rmux = w_cyc_lo;
            REG_MCYCLE_HI:   w_rmux = w_cyc_sh;
            REG_MINSTRET_LO: w_rmux = w_ins_lo;
            REG_MINSTRET_HI: w_rmux = w_ins_sh;
            REG_BR_PRED:     w_rmux = w_bp;
            REG_BR_MISP:     w_rmux = w_bm;
            default:         w_rmux = '0;
        endcase
    end

    // Run state: IDLE only for the first cycle out of reset; DONE is sticky.
    always_comb begin
        state_d   = state_q;
        ctrl_en_d = ctrl_en_q;
        tohost_d  = tohost_q;
        pass_d    = pass_q;
        rdata_d   = rdata_q;
        rdata_v_d = w_rd;
        case (state_q)
            ST_IDLE:    state_d = w_tohost_wr ? ST_DONE : ST_RUNNING;
            ST_RUNNING: state_d = w_tohost_wr ? ST_DONE : ST_RUNNING;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
        if (w_tohost_wr) begin
            tohost_d = dbus_wdata_i;
            pass_d   = (dbus_wdata_i == PASS_CODE);
        end
        if (w_wr && (w_idx == REG_CTRL)) begin
            ctrl_en_d = dbus_wdata_i[0];
        end
        if (w_rd) begin
            rdata_d = w_rmux;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ctrl_en_q <= 1'b1;
            tohost_q  <= '0;
            pass_q    <= 1'b0;
            rdata_q   <= '0;
            rdata_v_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_en_q <= ctrl_en_d;
            tohost_q  <= tohost_d;
            pass_q    <= pass_d;
            rdata_q   <= rdata_d;
            rdata_v_q <= rdata_v_d;
        end
    end

    assign fini_o         = (state_q == ST_DONE);
    assign pass_o         = pass_q;
    assign tohost_o       = tohost_q;
    assign dbus_rdata_o   = rdata_q;
    assign dbus_rdata_v_o = rdata_v_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_perf_tohost.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_perf_tohost
// Brief    : Self-checking bench for mmio_perf_tohost against a cycle-level
//            behavioural model of the register map and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_perf_tohost;
    import mmio_perf_tohost_pkg::*;

`ifdef PERF_BRANCH_CNT_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, wvalid, rvalid, retire, tsfr, misp;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata, tohost;
    logic        rdata_v, fini, pass;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_bp, m_bm, m_sh_cyc, m_sh_ins, m_tohost, m_rdata;
    logic        m_en, m_fini, m_pass, m_rv;

    always #5 clk = ~clk;

    mmio_perf_tohost dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .dbus_addr_i    (addr),
        .dbus_wvalid_i  (wvalid),
        .dbus_wdata_i   (wdata),
        .dbus_wstrb_i   (wstrb),
        .dbus_rvalid_i  (rvalid),
        .dbus_rdata_o   (rdata),
        .dbus_rdata_v_o (rdata_v),
        .retire_i       (retire),
        .ctrl_tsfr_i    (tsfr),
        .br_misp_i      (misp),
        .fini_o         (fini),
        .pass_o         (pass),
        .tohost_o       (tohost)
    );

    function automatic logic [31:0] m_value(input logic [2:0] idx);
        case (idx)
            3'd0:    return m_tohost;
            3'd1:    return {31'd0, m_en};
            3'd2:    return m_cyc[31:0];
            3'd3:    return m_sh_cyc;
            3'd4:    return m_ins[31:0];
            3'd5:    return m_sh_ins;
            3'd6:    return m_bp;
            default: return m_bm;
        endcase
    endfunction

    // Advance the model by one cycle from the currently driven inputs, then clock.
    task automatic step();
        logic [2:0] idx;
        logic       wr, rd, clr;
        idx = addr[4:2];
        wr  = addr[28] && wvalid && (wstrb == 4'hf);
        rd  = addr[28] && rvalid;
        if (rst) begin
            m_cyc = 0; m_ins = 0; m_bp = 0; m_bm = 0; m_sh_cyc = 0; m_sh_ins = 0;
            m_tohost = 0; m_fini = 0; m_pass = 0; m_en = 1; m_rv = 0; m_rdata = 0;
        end else begin
            m_rv = rd;
            if (rd) begin
                m_rdata = m_value(idx);
                if (idx == REG_MCYCLE_LO)   m_sh_cyc = m_cyc[63:32];
                if (idx == REG_MINSTRET_LO) m_sh_ins = m_ins[63:32];
            end
            clr = wr && (idx == REG_CTRL) && wdata[1];
            if (clr) begin
                m_cyc = 0; m_ins = 0; m_bp = 0; m_bm = 0;
            end else if (m_en && !m_fini) begin
                m_cyc = m_cyc + 1;
                if (retire) m_ins = m_ins + 1;
                if (BR_EN && tsfr) m_bp = m_bp + 1;
                if (BR_EN && tsfr && misp) m_bm = m_bm + 1;
            end
            if (wr && (idx == REG_TOHOST) && !m_fini) begin
                m_tohost = wdata; m_fini = 1'b1; m_pass = (wdata == 32'h777);
            end
            if (wr && (idx == REG_CTRL)) m_en = wdata[0];
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_addr(input logic [2:0] idx);
        return {3'b000, 1'b1, 23'd0, idx, 2'b00};
    endfunction

    task automatic drive_idle();
        wvalid = 0; rvalid = 0; retire = 0; tsfr = 0; misp = 0;
        wstrb = 4'hf; wdata = 0; addr = reg_addr(3'd0);
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d);
        addr = reg_addr(idx); wdata = d; wvalid = 1; step(); wvalid = 0;
    endtask

    task automatic rd_reg(input logic [2:0] idx);
        addr = reg_addr(idx); rvalid = 1; step(); rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1; retire = 1; rvalid = 1;
        step(); step();
        rst = 0; retire = 0; rvalid = 0;
        n_total++;
        if (rdata_v !== 1'b0 || rdata !== 32'd0) begin
            $display("FAIL reset_rdata: got v=%0b d=%h, want v=0 d=0", rdata_v, rdata);
        end else n_pass++;
        n_total++;
        if (fini !== 1'b0 || pass !== 1'b0 || tohost !== 32'd0) begin
            $display("FAIL reset_tohost: got fini=%0b pass=%0b tohost=%h, want 0/0/0", fini, pass, tohost);
        end else n_pass++;
        rd_reg(REG_CTRL);
        n_total++;
        if (rdata_v !== 1'b1 || rdata !== 32'd1) begin
            $display("FAIL reset_ctrl: got v=%0b d=%h, want v=1 d=1", rdata_v, rdata);
        end else n_pass++;
        step();
        n_total++;
        if (rdata_v !== 1'b0 || rdata !== 32'd1) begin
            $display("FAIL rvalid_drop: got v=%0b d=%h, want v=0 d=1 (held)", rdata_v, rdata);
        end else n_pass++;
    endtask

    task automatic test_mcycle();
        do_reset();
        repeat (10) step();
        rd_reg(REG_MCYCLE_LO);
        n_total++;
        if (rdata_v !== 1'b1 || rdata !== m_rdata || rdata < 9 || rdata > 11) begin
            $display("FAIL mcycle_lo: got v=%0b d=%0d, want v=1 d=%0d", rdata_v, rdata, m_rdata);
        end else n_pass++;
        rd_reg(REG_MCYCLE_HI);
        n_total++;
        if (rdata_v !== 1'b1 || rdata !== 32'd0) begin
            $display("FAIL mcycle_hi: got v=%0b d=%h, want v=1 d=0", rdata_v, rdata);
        end else n_pass++;
    endtask

    task automatic test_minstret();
        wr_reg(REG_CTRL, 32'd3);
        for (int i = 0; i < 5; i++) begin
            retire = 1; step(); retire = 0;
            repeat ($urandom_range(0, 3)) step();
        end
        rd_reg(REG_MINSTRET_LO);
        n_total++;
        if (rdata_v !== 1'b1 || rdata !== 32'd5 || rdata !== m_rdata) begin
            $display("FAIL minstret_lo: got v=%0b d=%0d, want v=1 d=5", rdata_v, rdata);
        end else n_pass++;
    endtask

    task automatic test_clear_collisions();
        retire = 1; step(); step();
        addr = reg_addr(REG_CTRL); wdata = 32'd3; wvalid = 1;
        step();
        wvalid = 0; retire = 0;
        rd_reg(REG_MINSTRET_LO);
        n_total++;
        if (rdata !== 32'd0 || rdata !== m_rdata) begin
            $display("FAIL clear_wins: got %0d, want 0", rdata);
        end else n_pass++;
        // Read and write to CTRL together: read returns the pre-write value.
        addr = reg_addr(REG_CTRL); wdata = 32'd0; wvalid = 1; rvalid = 1;
        step();
        wvalid = 0; rvalid = 0;
        n_total++;
        if (rdata_v !== 1'b1 || rdata !== 32'd1) begin
            $display("FAIL rw_same_cycle: got v=%0b d=%h, want v=1 d=1", rdata_v, rdata);
        end else n_pass++;
        rd_reg(REG_CTRL);
        n_total++;
        if (rdata !== 32'd0) begin
            $display("FAIL ctrl_written: got %h, want 0", rdata);
        end else n_pass++;
        wr_reg(REG_CTRL, 32'd1);
    endtask

    task automatic test_ignored();
        logic [31:0] held;
        wstrb = 4'h7; wr_reg(REG_CTRL, 32'd0); wstrb = 4'hf;
        rd_reg(REG_CTRL);
        n_total++;
        if (rdata !== 32'd1) begin
            $display("FAIL partial_write: got ctrl=%h, want 1", rdata);
        end else n_pass++;
        retire = 1; wr_reg(REG_MINSTRET_LO, 32'hDEAD_0000); retire = 0;
        rd_reg(REG_MINSTRET_LO);
        n_total++;
        if (rdata !== m_rdata) begin
            $display("FAIL ro_counter: got %h, want %h", rdata, m_rdata);
        end else n_pass++;
        held = rdata;
        addr = 32'h0000_0000; rvalid = 1; wvalid = 1; wdata = 32'h777;
        step();
        rvalid = 0; wvalid = 0;
        n_total++;
        if (rdata_v !== 1'b0 || rdata !== held || fini !== 1'b0) begin
            $display("FAIL unselected: got v=%0b d=%h fini=%0b, want v=0 d=%h fini=0", rdata_v, rdata, fini, held);
        end else n_pass++;
    endtask

    task automatic test_branch();
        int k;
        wr_reg(REG_CTRL, 32'd3);
        k = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
            tsfr = 1; misp = (i == k); step();
        end
        tsfr = 0; misp = 1; step(); misp = 0;
        rd_reg(REG_BR_PRED);
        n_total++;
        if (rdata !== (BR_EN ? 32'd4 : 32'd0) || rdata !== m_rdata) begin
            $display("FAIL br_pred: got %0d, want %0d", rdata, BR_EN ? 4 : 0);
        end else n_pass++;
        rd_reg(REG_BR_MISP);
        n_total++;
        if (rdata !== (BR_EN ? 32'd1 : 32'd0) || rdata !== m_rdata) begin
            $display("FAIL br_misp: got %0d, want %0d", rdata, BR_EN ? 1 : 0);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        wr_reg(REG_CTRL, 32'd2);
        force dut.u_mcycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_mcycle.cnt_q;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        wr_reg(REG_CTRL, 32'd1);
        wr_reg(REG_CTRL, 32'd0);
        rd_reg(REG_MCYCLE_LO);
        n_total++;
        if (rdata !== 32'd0 || rdata !== m_rdata) begin
            $display("FAIL wrap_lo: got %h, want 0", rdata);
        end else n_pass++;
        rd_reg(REG_MCYCLE_HI);
        n_total++;
        if (rdata !== 32'd1 || rdata !== m_rdata) begin
            $display("FAIL wrap_hi: got %h, want 1", rdata);
        end else n_pass++;
        wr_reg(REG_CTRL, 32'd1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            retire = 1'($urandom_range(0, 1));
            tsfr   = 1'($urandom_range(0, 1));
            misp   = 1'($urandom_range(0, 1));
            rvalid = ($urandom_range(0, 2) == 0);
            addr   = reg_addr(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 15) == 0) begin
                addr = reg_addr(REG_CTRL); wvalid = 1;
                wdata = {30'd0, 1'($urandom_range(0, 1)), 1'b1};
            end
            step();
            wvalid = 0;
            n_total++;
            if (rdata_v !== m_rv || (m_rv && rdata !== m_rdata)) begin
                $display("FAIL random_read[%0d]: got v=%0b d=%h, want v=%0b d=%h", i, rdata_v, rdata, m_rv, m_rdata);
            end else n_pass++;
        end
        drive_idle();
        wr_reg(REG_CTRL, 32'd1);
    endtask

    task automatic test_tohost_pass();
        logic [31:0] first;
        repeat ($urandom_range(2, 6)) begin retire = 1; step(); end
        retire = 1; wr_reg(REG_TOHOST, 32'h777); retire = 0;
        n_total++;
        if (fini !== 1'b1 || pass !== 1'b1 || tohost !== 32'h777) begin
            $display("FAIL tohost_pass: got fini=%0b pass=%0b tohost=%h, want 1/1/777", fini, pass, tohost);
        end else n_pass++;
        wr_reg(REG_TOHOST, 32'h1);
        n_total++;
        if (fini !== 1'b1 || pass !== 1'b1 || tohost !== 32'h777) begin
            $display("FAIL tohost_sticky: got fini=%0b pass=%0b tohost=%h, want 1/1/777", fini, pass, tohost);
        end else n_pass++;
        rd_reg(REG_MCYCLE_LO);
        first = rdata;
        repeat (5) begin retire = 1; step(); end
        retire = 0;
        rd_reg(REG_MCYCLE_LO);
        n_total++;
        if (rdata !== first || rdata !== m_rdata) begin
            $display("FAIL mcycle_frozen: got %0d, want %0d", rdata, m_rdata);
        end else n_pass++;
        rd_reg(REG_MINSTRET_LO);
        n_total++;
        if (rdata !== m_rdata) begin
            $display("FAIL minstret_frozen: got %0d, want %0d", rdata, m_rdata);
        end else n_pass++;
        rd_reg(REG_TOHOST);
        n_total++;
        if (rdata !== 32'h777) begin
            $display("FAIL tohost_read: got %h, want 777", rdata);
        end else n_pass++;
    endtask

    task automatic test_tohost_fail();
        addr = reg_addr(REG_TOHOST); rvalid = 1; rst = 1;
        step();
        rst = 0; rvalid = 0;
        n_total++;
        if (rdata_v !== 1'b0 || rdata !== 32'd0 || fini !== 1'b0) begin
            $display("FAIL reset_midrun: got v=%0b d=%h fini=%0b, want 0/0/0", rdata_v, rdata, fini);
        end else n_pass++;
        step();
        wr_reg(REG_TOHOST, 32'h123);
        n_total++;
        if (fini !== 1'b1 || pass !== 1'b0 || tohost !== 32'h123) begin
            $display("FAIL tohost_fail: got fini=%0b pass=%0b tohost=%h, want 1/0/123", fini, pass, tohost);
        end else n_pass++;
    endtask

    initial begin
        rst = 1;
        drive_idle();
        test_reset();
        test_mcycle();
        test_minstret();
        test_clear_collisions();
        test_ignored();
        test_branch();
        test_wrap();
        test_random();
        test_tohost_pass();
        test_tohost_fail();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_perf_tohost.md
Name: mmio_perf_tohost

Overview:
- Memory-mapped slave on the CPU data bus that decodes the MMIO region selected by dbus address bit 28.
- Consumes the CPU's end-of-test ("tohost") store and exposes cycle, retired-instruction and branch counters to software.
- Sits directly downstream of the CPU dbus port, in parallel with data memory, inside main.
- Provides fini_o/pass_o so the simulation bench and the FPGA top share one end-of-run mechanism.

Parameters:
- PASS_CODE, 32'h777, tohost value meaning pass.
- REGION_BIT, 28, address bit that selects this block.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- dbus_addr_i  in  32  byte address; block selected when bit REGION_BIT=1; register = addr[4:2].
- dbus_wvalid_i  in  1  write request, single cycle.
- dbus_wdata_i  in  32  write data.
- dbus_wstrb_i  in  4  byte strobes.
- dbus_rvalid_i  in  1  read request, single cycle.
- dbus_rdata_o  out  32  read data.
- dbus_rdata_v_o  out  1  read data valid.
- retire_i  in  1  one instruction retired this cycle (non-stalled, valid ExMa).
- ctrl_tsfr_i  in  1  control-transfer instruction resolved this cycle.
- br_misp_i  in  1  that control transfer was mispredicted (qualified by ctrl_tsfr_i).
- fini_o  out  1  tohost written; sticky.
- pass_o  out  1  tohost value == PASS_CODE; valid while fini_o=1.
- tohost_o  out  32  captured tohost value.

Behaviour:
- Register map (addr[4:2]):
  - 0 TOHOST (R/W).
  - 1 CTRL: bit0 = count enable, reset 1; bit1 = clear, write-1 self-clearing, reads 0.
  - 2 MCYCLE_LO, 3 MCYCLE_HI.
  - 4 MINSTRET_LO, 5 MINSTRET_HI.
  - 6 BR_PRED, 7 BR_MISP.
  - Counter registers are read-only; writes to them are ignored.
- Writes:
  - Accepted only when selected, dbus_wvalid_i=1 and dbus_wstrb_i=4'hf; partial writes are ignored.
  - Zero wait states.
- Reads:
  - Request at cycle N yields dbus_rdata_o and dbus_rdata_v_o=1 at N+1.
  - dbus_rdata_v_o=0 otherwise; dbus_rdata_o holds its last value.
  - Unselected addresses produce no response.
- Counters:
  - mcycle and minstret are 64-bit; BR_PRED and BR_MISP are 32-bit. All wrap to 0 at all-ones.
  - Increment only while CTRL.bit0=1 and fini_o=0.
  - mcycle +1 every cycle.
  - minstret +1 on retire_i.
  - BR_PRED +1 on ctrl_tsfr_i; BR_MISP +1 on ctrl_tsfr_i & br_misp_i.
- 64-bit snapshot:
  - A read of *_LO latches the matching upper word into a shadow register in the same cycle.
  - A read of *_HI returns the shadow. Reading HI without a prior LO read returns the stale shadow (0 after reset).
- TOHOST:
  - First accepted write captures tohost_o, sets fini_o=1, and sets pass_o=(data==PASS_CODE).
  - Later writes are ignored; the first result wins.
- End-of-run state machine: IDLE -> RUNNING on reset release; RUNNING -> DONE on tohost write. DONE is left only by rst_i.
- Simultaneous events:
  - Clear and increment in the same cycle: the counter becomes 0 (clear wins).
  - A tohost write and an event in the same cycle: the event is counted, and counting freezes from the next cycle.
  - A read in the same cycle as a clear returns the pre-clear value.
  - A read and a write in the same cycle are both served.
- Reset values: all outputs, counters and shadows are 0, except CTRL.bit0=1.
  - Reset mid-run zeroes everything in the next cycle and abandons any pending read valid.

Optional Feature:
- Macro PERF_BRANCH_CNT_EN.
  - Defined: BR_PRED and BR_MISP are implemented as described above.
  - Undefined: those counters are not instantiated; offsets 6 and 7 read 0; ctrl_tsfr_i and br_misp_i are ignored.

Decomposition:
- Shared package holds: register offset localparams, PASS_CODE default, and the run-state enum (IDLE/RUNNING/DONE).
- One sub-module, perf_cnt64: a 64-bit counter with enable, clear and LO-read snapshot.
  - Instantiated for mcycle and minstret.
  - The 32-bit branch counters are inline.

Test Plan:
- Release reset, wait 10 cycles, read MCYCLE_LO then MCYCLE_HI -> LO = 10±1, HI = 0, dbus_rdata_v_o one cycle after each request.
- Pulse retire_i 5 times, read MINSTRET_LO -> 5.
- Write 32'h777 to TOHOST, then 32'h1 -> fini_o=1, pass_o=1, tohost_o=32'h777, and mcycle frozen on later reads.
- Write 32'h123 to TOHOST -> fini_o=1, pass_o=0.
- Force mcycle to 32'hFFFF_FFFF via CTRL clear + hierarchical preset, step 1 cycle, read LO then HI -> LO=0, HI=1.
- Drive ctrl_tsfr_i 4 cycles with br_misp_i on 1 of them -> BR_PRED=4, BR_MISP=1 (0 and 0 with PERF_BRANCH_CNT_EN undefined).
- Write CTRL=2 in the same cycle as retire_i -> MINSTRET=0.
